// File: rtl/bidir_io_bank_pkg.sv
// Shared types and constants for the bidirectional pad bank.
// State encoding is fixed so it can be observed on a debug bus.
package bidir_io_bank_pkg;

  typedef enum logic [1:0] {
    HIZ      = 2'd0,
    TURN_ON  = 2'd1,
    DRIVE    = 2'd2,
    TURN_OFF = 2'd3
  } state_e;

  localparam int CNT_W  = 4;  // turnaround counter, covers TURN_CYCLES up to 15
  localparam int VCNT_W = 3;  // din_valid counter, covers SYNC_STAGES up to 4

endpackage

// File: rtl/bidir_io_bank_io_sync_chain.sv
// Multi-stage synchroniser for the pad input path.
// Samples every cycle; q is the last stage, SYNC_STAGES cycles behind d.
module io_sync_chain #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] stg_q, stg_d;

  always_comb begin
    stg_d[0] = d;
    for (int i = 1; i < SYNC_STAGES; i++) stg_d[i] = stg_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (reset) stg_q <= '0;
    else       stg_q <= stg_d;
  end

  assign q = stg_q[SYNC_STAGES-1];

endmodule

// File: rtl/bidir_io_bank.sv
// Bidirectional pad bank: bus-ownership FSM with turnaround dead cycles,
// registered tristate drivers and a synchronised input path.
module bidir_io_bank
  import bidir_io_bank_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire  [WIDTH-1:0] io,
  input  logic [WIDTH-1:0] dout,
  input  logic             drive_req,
  output logic             drive_ack,
  output logic [WIDTH-1:0] din,
  output logic             din_valid,
  output logic             busy
);

  localparam bit                NO_TURN   = (TURN_CYCLES == 0);
  localparam logic [CNT_W-1:0]  TURN_LOAD = NO_TURN ? '0 : CNT_W'(TURN_CYCLES - 1);
  localparam logic [VCNT_W-1:0] VSAT      = VCNT_W'(SYNC_STAGES);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                oe_q, oe_d;
  logic [WIDTH-1:0]    out_q, out_d;
  logic [VCNT_W-1:0]   vcnt_q, vcnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HIZ;
      cnt_q   <= '0;
      oe_q    <= 1'b0;
      out_q   <= '0;
      vcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      oe_q    <= oe_d;
      out_q   <= out_d;
      vcnt_q  <= vcnt_d;
    end
  end

  // Aborting TURN_ON returns straight to HIZ: nothing was driven yet.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      HIZ: if (drive_req) begin
        state_d = NO_TURN ? DRIVE : TURN_ON;
        cnt_d   = TURN_LOAD;
      end
      TURN_ON: begin
        if (!drive_req)        state_d = HIZ;
        else if (cnt_q == '0)  state_d = DRIVE;
        else                   cnt_d   = cnt_q - 1'b1;
      end
      DRIVE: if (!drive_req) begin
        state_d = NO_TURN ? HIZ : TURN_OFF;
        cnt_d   = TURN_LOAD;
      end
      TURN_OFF: begin
        if (cnt_q == '0) state_d = HIZ;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = HIZ;
    endcase
  end

  // Output data follows dout while the next state is DRIVE, so the first
  // driven value is the one presented on the entry edge.
  always_comb begin
    oe_d  = (state_d == DRIVE);
    out_d = (state_d == DRIVE) ? dout : out_q;
  end

  always_comb begin
    vcnt_d = vcnt_q;
    if (state_q != HIZ)    vcnt_d = '0;
    else if (vcnt_q < VSAT) vcnt_d = vcnt_q + 1'b1;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign io[i] = oe_q ? out_q[i] : 1'bz;
  end

  io_sync_chain #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (io),
    .q     (din)
  );

  assign drive_ack = oe_q;
  assign busy      = (state_q == TURN_ON) || (state_q == TURN_OFF);
  assign din_valid = (state_q == HIZ) && (vcnt_q >= VSAT);

endmodule

// File: tb/tb_bidir_io_bank.sv
// Directed bench for bidir_io_bank: one instance with 2 turnaround cycles,
// one with none; the bench owns the bus only while the DUT should not.
module tb_bidir_io_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic       drive_req, drive_req0;
  logic [7:0] dout, dout0;
  logic       ext_en, ext_en0;
  logic [7:0] ext_val, ext_val0;
  wire  [7:0] io, io0;
  logic [7:0] din, din0;
  logic       drive_ack, drive_ack0, din_valid, din_valid0, busy, busy0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign io  = ext_en  ? ext_val  : 8'bz;
  assign io0 = ext_en0 ? ext_val0 : 8'bz;

  bidir_io_bank #(.WIDTH(8), .TURN_CYCLES(2), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .io(io), .dout(dout), .drive_req(drive_req),
    .drive_ack(drive_ack), .din(din), .din_valid(din_valid), .busy(busy)
  );

  bidir_io_bank #(.WIDTH(8), .TURN_CYCLES(0), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .reset(reset), .io(io0), .dout(dout0), .drive_req(drive_req0),
    .drive_ack(drive_ack0), .din(din0), .din_valid(din_valid0), .busy(busy0)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; drive_req = 1'b0; drive_req0 = 1'b0;
    dout = 8'h00; dout0 = 8'h00;
    ext_en = 1'b1; ext_val = 8'hA5; ext_en0 = 1'b1; ext_val0 = 8'h11;
    tick; tick;
    total++; if (drive_ack !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b want=0", drive_ack); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (din_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", din_valid); end
    total++; if (din !== 8'h00) begin bad++; $display("FAIL rst_din got=%h want=00", din); end
    reset = 1'b0;
    tick;
    total++; if (din_valid !== 1'b0) begin bad++; $display("FAIL rel1_valid got=%b want=0", din_valid); end
    tick;
    total++; if (din !== 8'hA5) begin bad++; $display("FAIL rel2_din got=%h want=a5", din); end
    total++; if (din_valid !== 1'b1) begin bad++; $display("FAIL rel2_valid got=%b want=1", din_valid); end
    total++; if (drive_ack !== 1'b0) begin bad++; $display("FAIL rel2_ack got=%b want=0", drive_ack); end
  endtask

  task automatic test_drive_on;
    dout = 8'h3C; drive_req = 1'b1;
    tick;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL on1_busy got=%b want=1", busy); end
    total++; if (din_valid !== 1'b0) begin bad++; $display("FAIL on1_valid got=%b want=0", din_valid); end
    total++; if (drive_ack !== 1'b0) begin bad++; $display("FAIL on1_ack got=%b want=0", drive_ack); end
    tick;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL on2_busy got=%b want=1", busy); end
    total++; if (drive_ack !== 1'b0) begin bad++; $display("FAIL on2_ack got=%b want=0", drive_ack); end
    ext_en = 1'b0;
    tick;
    total++; if (drive_ack !== 1'b1) begin bad++; $display("FAIL on3_ack got=%b want=1", drive_ack); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL on3_busy got=%b want=0", busy); end
    total++; if (io !== 8'h3C) begin bad++; $display("FAIL on3_io got=%h want=3c", io); end
    dout = 8'h5A;
    tick;
    total++; if (io !== 8'h5A) begin bad++; $display("FAIL on4_io got=%h want=5a", io); end
  endtask

  task automatic test_drive_off;
    drive_req = 1'b0; dout = 8'hEE;
    tick;
    total++; if (drive_ack !== 1'b0) begin bad++; $display("FAIL off1_ack got=%b want=0", drive_ack); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL off1_busy got=%b want=1", busy); end
    ext_en = 1'b1; ext_val = 8'hC3;
    #1;
    total++; if (io !== 8'hC3) begin bad++; $display("FAIL off1_io got=%h want=c3", io); end
    tick;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL off2_busy got=%b want=1", busy); end
    drive_req = 1'b1;  // ignored during TURN_OFF
    tick;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL off3_busy got=%b want=0", busy); end
    total++; if (din_valid !== 1'b0) begin bad++; $display("FAIL off3_valid got=%b want=0", din_valid); end
    total++; if (drive_ack !== 1'b0) begin bad++; $display("FAIL off3_ack got=%b want=0", drive_ack); end
    drive_req = 1'b0;
    tick;
    total++; if (din_valid !== 1'b0) begin bad++; $display("FAIL off4_valid got=%b want=0", din_valid); end
    tick;
    total++; if (din_valid !== 1'b1) begin bad++; $display("FAIL off5_valid got=%b want=1", din_valid); end
    total++; if (din !== 8'hC3) begin bad++; $display("FAIL off5_din got=%h want=c3", din); end
  endtask

  task automatic test_glitch;
    drive_req = 1'b1;
    tick;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL gl1_busy got=%b want=1", busy); end
    total++; if (din_valid !== 1'b0) begin bad++; $display("FAIL gl1_valid got=%b want=0", din_valid); end
    drive_req = 1'b0;
    tick;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL gl2_busy got=%b want=0", busy); end
    total++; if (drive_ack !== 1'b0) begin bad++; $display("FAIL gl2_ack got=%b want=0", drive_ack); end
    tick;
    total++; if (drive_ack !== 1'b0) begin bad++; $display("FAIL gl3_ack got=%b want=0", drive_ack); end
    tick;
    total++; if (din_valid !== 1'b1) begin bad++; $display("FAIL gl4_valid got=%b want=1", din_valid); end
  endtask

  task automatic test_reset_in_drive;
    dout = 8'hFF; drive_req = 1'b1;
    tick; tick;
    ext_en = 1'b0;
    tick;
    total++; if (io !== 8'hFF) begin bad++; $display("FAIL rd_io got=%h want=ff", io); end
    total++; if (drive_ack !== 1'b1) begin bad++; $display("FAIL rd_ack got=%b want=1", drive_ack); end
    reset = 1'b1;
    tick;
    total++; if (drive_ack !== 1'b0) begin bad++; $display("FAIL rr_ack got=%b want=0", drive_ack); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rr_busy got=%b want=0", busy); end
    ext_en = 1'b1; ext_val = 8'h00;
    #1;
    total++; if (io !== 8'h00) begin bad++; $display("FAIL rr_io got=%h want=00", io); end
    tick;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rr2_busy got=%b want=0", busy); end
    reset = 1'b0; drive_req = 1'b0;
    tick;
    total++; if (din_valid !== 1'b0) begin bad++; $display("FAIL rr3_valid got=%b want=0", din_valid); end
    tick;
    total++; if (din_valid !== 1'b1) begin bad++; $display("FAIL rr4_valid got=%b want=1", din_valid); end
  endtask

  task automatic test_zero_turn;
    dout0 = 8'h96; drive_req0 = 1'b1; ext_en0 = 1'b0;
    tick;
    total++; if (drive_ack0 !== 1'b1) begin bad++; $display("FAIL z1_ack got=%b want=1", drive_ack0); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL z1_busy got=%b want=0", busy0); end
    total++; if (io0 !== 8'h96) begin bad++; $display("FAIL z1_io got=%h want=96", io0); end
    tick;
    total++; if (drive_ack0 !== 1'b1) begin bad++; $display("FAIL z2_ack got=%b want=1", drive_ack0); end
    drive_req0 = 1'b0;
    tick;
    total++; if (drive_ack0 !== 1'b0) begin bad++; $display("FAIL z3_ack got=%b want=0", drive_ack0); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL z3_busy got=%b want=0", busy0); end
    ext_en0 = 1'b1; ext_val0 = 8'h11;
    #1;
    total++; if (io0 !== 8'h11) begin bad++; $display("FAIL z3_io got=%h want=11", io0); end
    tick;
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL z4_busy got=%b want=0", busy0); end
  endtask

  initial begin
    test_reset;
    test_drive_on;
    test_drive_off;
    test_glitch;
    test_reset_in_drive;
    test_zero_turn;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
